// File: rtl/uart_word_tx_fifo.sv
// uart_word_tx_fifo
// Word queue in front of the byte-level UART sender. 32-bit words pushed by
// the pipeline are buffered in a circular FIFO, then each word is sent as
// four bytes, MSB first. Each byte uses a one-cycle send strobe and a
// level-ready handshake with the sender.
module uart_word_tx_fifo #(
    parameter int DEPTH_WIDTH = 3
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [31:0]            push_data,
    input  logic                   push_enable,
    input  logic                   sender_ready,
    output logic [7:0]             sender_data,
    output logic                   sender_enable,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_WIDTH:0]   count,
    output logic                   busy,
    output logic                   overflow
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FULL_COUNT = {1'b1, {DEPTH_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]            mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wptr;
    logic [DEPTH_WIDTH-1:0] rptr;
    logic [31:0]            shift;
    logic [1:0]             byte_idx;

    logic pop;
    logic push_ok;
    logic strobe;
    logic advance;

    // Flags come from the registered count only, so no path from push_enable.
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign busy  = (state != IDLE);

    // A push into a full FIFO still fits when the serializer pops this cycle.
    assign push_ok = push_enable && (!full || pop);

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the per-cycle pop / strobe / shift decisions.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        strobe     = 1'b0;
        advance    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (sender_ready) begin
                    strobe     = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // The sender dropping ready acknowledges the byte.
                if (!sender_ready) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (sender_ready) begin
                    if (byte_idx == 2'd3) begin
                        state_next = IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = SEND;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (push_enable && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Shift register, byte index and the registered sender interface.
    always_ff @(posedge CLK) begin
        if (reset) begin
            shift         <= '0;
            byte_idx      <= '0;
            sender_data   <= '0;
            sender_enable <= 1'b0;
        end else begin
            sender_enable <= strobe;
            if (strobe) begin
                sender_data <= shift[31:24];
            end
            if (pop) begin
                shift    <= mem[rptr];
                byte_idx <= '0;
            end else if (advance) begin
                shift    <= {shift[23:0], 8'h00};
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_tx_fifo.sv
// Testbench for uart_word_tx_fifo: directed words with a scoreboard of
// expected bytes, a behavioural byte sender, and a strobe monitor.
module tb_uart_word_tx_fifo;

    logic        CLK;
    logic        reset;
    logic [31:0] push_data;
    logic        push_enable;
    logic        sender_ready;
    logic [7:0]  sender_data;
    logic        sender_enable;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        busy;
    logic        overflow;

    int vectors = 0;
    int errors  = 0;
    int strobes = 0;

    logic [7:0] exp_q[$];

    // Sender model controls
    bit hold      = 1'b0;
    int ack_delay = 0;

    uart_word_tx_fifo #(.DEPTH_WIDTH(3)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .push_data    (push_data),
        .push_enable  (push_enable),
        .sender_ready (sender_ready),
        .sender_data  (sender_data),
        .sender_enable(sender_enable),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .busy         (busy),
        .overflow     (overflow)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // Byte sender model: after a strobe, optionally stays ready for
    // ack_delay cycles, then is busy (ready low) for 10 cycles.
    initial begin
        int dly;
        int bcnt;
        dly  = 0;
        bcnt = 0;
        sender_ready = 1'b1;
        forever begin
            @(negedge CLK);
            if (dly > 0) begin
                dly--;
                if (dly == 0) bcnt = 10;
            end else if (bcnt > 0) begin
                bcnt--;
            end
            if (sender_enable === 1'b1) begin
                if (ack_delay == 0) bcnt = 10;
                else                dly  = ack_delay;
            end
            sender_ready = !hold && (bcnt == 0);
        end
    end

    // Monitor: every strobe pops one expected byte from the scoreboard.
    initial begin
        logic       prev_en;
        logic [7:0] e;
        prev_en = 1'b0;
        forever begin
            @(negedge CLK);
            if (sender_enable === 1'b1) begin
                strobes++;
                vectors++;
                if (prev_en) begin
                    errors++;
                    $display("FAIL double_strobe: enable high two cycles, data=%02h", sender_data);
                end
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got byte %02h, required no strobe", sender_data);
                end else begin
                    e = exp_q.pop_front();
                    if (sender_data !== e) begin
                        errors++;
                        $display("FAIL byte: got %02h, required %02h", sender_data, e);
                    end
                end
            end
            prev_en = sender_enable;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Drive one push on the next edge; caller releases push_enable.
    task automatic push(input logic [31:0] w);
        @(negedge CLK);
        push_data   = w;
        push_enable = 1'b1;
    endtask

    task automatic release_push();
        @(negedge CLK);
        push_enable = 1'b0;
    endtask

    // Wait until all expected bytes are sent and the block is idle/empty.
    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && busy === 1'b0 && empty === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_drain_done"}, {31'd0, done}, 32'd1);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_empty"}, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        int base;
        bit seen;
        reset       = 1'b1;
        push_data   = 32'h0;
        push_enable = 1'b0;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_sender_data", {24'd0, sender_data}, 32'h0);
        check("rst_sender_enable", {31'd0, sender_enable}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;

        // Single word with 10-cycle-busy sender
        expect_word(32'hDEADBEEF);
        push(32'hDEADBEEF);
        release_push();
        drain("deadbeef");

        // Fill while sender is held not-ready: 9 pushes, 10th overflows
        hold = 1'b1;
        repeat (2) @(negedge CLK);
        for (int i = 1; i <= 9; i++) begin
            expect_word(i);
            push(i);
        end
        @(negedge CLK);
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_count", {28'd0, count}, 32'd8);
        check("fill_overflow", {31'd0, overflow}, 32'd0);
        check("fill_busy", {31'd0, busy}, 32'd1);
        push_data = 32'hAAAAAAAA;
        @(negedge CLK);
        push_enable = 1'b0;
        check("ovf_overflow", {31'd0, overflow}, 32'd1);
        check("ovf_count", {28'd0, count}, 32'd8);

        // Release sender; push on the IDLE pop cycle while full
        hold = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check("idle_reached", {31'd0, seen}, 32'd1);
        check("idle_full", {31'd0, full}, 32'd1);
        expect_word(32'h0000000B);
        push_data   = 32'h0000000B;
        push_enable = 1'b1;
        @(negedge CLK);
        push_enable = 1'b0;
        check("pushpop_count", {28'd0, count}, 32'd8);
        check("pushpop_full", {31'd0, full}, 32'd1);
        check("pushpop_busy", {31'd0, busy}, 32'd1);
        drain("wrap");

        // Sender held not-ready for 50 cycles in SEND
        hold = 1'b1;
        repeat (2) @(negedge CLK);
        expect_word(32'hCAFEF00D);
        push(32'hCAFEF00D);
        release_push();
        repeat (50) begin
            @(negedge CLK);
            check("hold_no_strobe", {31'd0, sender_enable}, 32'd0);
        end
        check("hold_busy", {31'd0, busy}, 32'd1);
        ack_delay = 3;
        hold      = 1'b0;
        drain("hold");
        ack_delay = 0;

        // Reset during byte 2 with 3 words queued
        base = strobes;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        push(32'h11223344);
        push(32'h01020304);
        push(32'h05060708);
        push(32'h090A0B0C);
        release_push();
        check("rst_mid_count", {28'd0, count}, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (strobes >= base + 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_mid_second_byte", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        check("rst_mid_count0", {28'd0, count}, 32'd0);
        check("rst_mid_empty", {31'd0, empty}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_overflow", {31'd0, overflow}, 32'd0);
        check("rst_mid_data", {24'd0, sender_data}, 32'h0);
        repeat (80) @(negedge CLK);
        check("rst_mid_strobes", strobes - base, 32'd2);
        check("rst_mid_queue", exp_q.size(), 32'd0);

        // push_data changes right after the push edge
        expect_word(32'h5A5AA5A5);
        push(32'h5A5AA5A5);
        @(negedge CLK);
        push_enable = 1'b0;
        push_data   = 32'hFFFFFFFF;
        drain("capture");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
